// File: rtl/io_timer.sv
// Memory-mapped down-counting timer with prescaler, one-shot/auto-reload modes,
// sticky expiry flag (write-1-to-clear) and an interrupt request gated by IE.
module io_timer #(
    parameter int PRESC_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wtData,
    output logic [31:0] rdData,
    output logic        intimer
);

    logic               ctrlEn;
    logic               ctrlAuto;
    logic               ctrlIe;
    logic [31:0]        loadReg;
    logic [31:0]        countReg;
    logic               expFlag;
    logic [PRESC_W-1:0] prescReg;
    logic [PRESC_W-1:0] pcnt;

    logic       wrEn;
    logic [2:0] sel;
    logic       ctrlWr;
    logic       loadWr;
    logic       countWr;
    logic       statusWr;
    logic       prescWr;
    logic       tick;
    logic       expire;
    logic       enNext;
    logic       unusedAddrBits;

    assign sel      = addr[4:2];
    assign wrEn     = ce & we;
    assign ctrlWr   = wrEn && (sel == 3'd0);
    assign loadWr   = wrEn && (sel == 3'd1);
    assign countWr  = wrEn && (sel == 3'd2);
    assign statusWr = wrEn && (sel == 3'd3);
    assign prescWr  = wrEn && (sel == 3'd4);

    assign tick   = ctrlEn && (pcnt == prescReg);
    assign expire = tick && (countReg == 32'd0);

    assign unusedAddrBits = ^{addr[31:5], addr[1:0]};

    // A software write to CTRL always overrides the one-shot auto-disable.
    always_comb begin
        enNext = ctrlEn;
        if (ctrlWr) begin
            enNext = wtData[0];
        end else if (expire && !ctrlAuto) begin
            enNext = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrlEn   <= 1'b0;
            ctrlAuto <= 1'b0;
            ctrlIe   <= 1'b0;
            loadReg  <= 32'd0;
            countReg <= 32'd0;
            expFlag  <= 1'b0;
            prescReg <= '0;
            pcnt     <= '0;
        end else begin
            ctrlEn <= enNext;
            if (ctrlWr) begin
                ctrlAuto <= wtData[1];
                ctrlIe   <= wtData[2];
            end
            if (loadWr) begin
                loadReg <= wtData;
            end
            if (prescWr) begin
                prescReg <= wtData[PRESC_W-1:0];
            end

            // Restart the prescaler phase whenever the timer is (re)enabled or stopped.
            if (!enNext || (ctrlWr && !ctrlEn) || tick) begin
                pcnt <= '0;
            end else begin
                pcnt <= pcnt + PRESC_W'(1);
            end

            if (countWr) begin
                countReg <= wtData;
            end else if (tick) begin
                if (countReg != 32'd0) begin
                    countReg <= countReg - 32'd1;
                end else if (ctrlAuto) begin
                    countReg <= loadReg;
                end
            end

            // Expiry beats a simultaneous clear so no event is ever lost.
            if (expire) begin
                expFlag <= 1'b1;
            end else if (statusWr && wtData[0]) begin
                expFlag <= 1'b0;
            end
        end
    end

    assign intimer = expFlag & ctrlIe;

    always_comb begin
        rdData = 32'd0;
        if (ce && !we) begin
            case (sel)
                3'd0:    rdData = {29'd0, ctrlIe, ctrlAuto, ctrlEn};
                3'd1:    rdData = loadReg;
                3'd2:    rdData = countReg;
                3'd3:    rdData = {31'd0, expFlag};
                3'd4:    rdData = 32'(prescReg);
                default: rdData = 32'd0;
            endcase
        end
    end

endmodule
